// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front end.
//
// Issues word-aligned fetch requests to instruction memory and queues the
// returned words with their PCs for decode. Taken branches and jumps flush the
// queue and restart fetch at the new PC. Responses to requests that were
// already in flight when the redirect happened are counted and discarded.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
// edge where valid and ready are both 1. Valid never depends on ready. The
// response channel has no ready, and the credit rule guarantees room for
// every response that is kept.
//
// Ports:
//   clk, reset        single clock; synchronous active-high reset
//   imem_req_valid    fetch request offered (output)
//   imem_req_ready    memory accepts the request (input)
//   imem_req_addr     word-aligned fetch address (output, 32)
//   imem_resp_valid   instruction word returned, in request order (input)
//   imem_resp_data    returned instruction word (input, 32)
//   redirect_valid    taken branch/jump: flush and refetch (input)
//   redirect_pc       new fetch address; bits [1:0] ignored (input, 32)
//   inst_valid        queue head valid to decode (output)
//   inst_ready        decode consumes the head (input)
//   inst_data         head instruction, 0 when empty (output, 32)
//   inst_pc           PC of head instruction, 0 when empty (output, 32)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = CW + 2;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] live;
  logic [CW-1:0] drop;

  logic [SW-1:0] credits_used;
  logic [CW-1:0] inflight;
  logic          req_fire;
  logic          resp_drop;
  logic          resp_push;
  logic          pop;
  logic          unused_redirect_lsbs;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Queue slots and in-flight requests share one budget. Every kept
  // response therefore has a free slot waiting for it, and the response
  // channel needs no back-pressure.
  assign credits_used = SW'(count) + SW'(live) + SW'(drop);
  assign inflight     = live + drop;

  assign imem_req_valid = !reset && !redirect_valid && (credits_used < SW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses to requests issued before a redirect are discarded first.
  // A response that arrives while nothing is in flight is a stray from before
  // a reset, and it is ignored.
  assign resp_drop = imem_resp_valid && (drop != '0);
  assign resp_push = imem_resp_valid && (drop == '0) && (live != '0);

  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign inst_data  = inst_valid ? q_data[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? q_pc[rd_ptr]   : '0;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Queue storage needs no reset. The pointers and count decide what is visible.
  always_ff @(posedge clk) begin
    if (resp_push && !redirect_valid) begin
      q_pc[wr_ptr]   <= resp_pc;
      q_data[wr_ptr] <= imem_resp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      live     <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      resp_pc  <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      live     <= '0;
      // Every request still in flight becomes a drop. A response arriving
      // this same cycle settles one of them now.
      drop     <= (imem_resp_valid && (inflight != '0)) ? inflight - CW'(1) : inflight;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (resp_push) begin
        wr_ptr  <= ptr_next(wr_ptr);
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (resp_drop) begin
        drop <= drop - CW'(1);
      end
      case ({req_fire, resp_push})
        2'b10:   live <= live + CW'(1);
        2'b01:   live <= live - CW'(1);
        default: ;
      endcase
      case ({resp_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. A second instance with RESET_PC near the top
// of the address space shares the main stimulus. It is used to observe
// address wrap-around.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_resp_valid;
  logic [31:0] w_resp_data;
  logic        w_inst_valid;
  logic [31:0] w_inst_data;
  logic [31:0] w_inst_pc;

  logic        mem_auto;
  int          total;
  int          bad;
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(w_req_addr),
    .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(w_inst_valid), .inst_ready(inst_ready),
    .inst_data(w_inst_data), .inst_pc(w_inst_pc)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock. When mem_auto is set, a 1-cycle memory answers each
  // accepted request with its own address as the data.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    logic        w_acc;
    logic [31:0] wa;
    #2;
    acc   = imem_req_valid && imem_req_ready;
    a     = imem_req_addr;
    w_acc = w_req_valid && imem_req_ready;
    wa    = w_req_addr;
    @(posedge clk);
    #1;
    if (mem_auto) begin
      imem_resp_valid = acc;
      imem_resp_data  = a;
    end
    w_resp_valid = w_acc;
    w_resp_data  = wa;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mem_auto        = 1'b1;
    reset           = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    w_resp_valid    = 1'b0;
    w_resp_data     = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    inst_ready      = 1'b1;

    // reset state
    tick();
    tick();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);

    // streaming with 1-cycle memory and decode always ready
    exp_q = {32'h0, 32'h4, 32'h8};
    reset = 1'b0;
    #1;
    chk("c0_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("c0_req_addr", imem_req_addr, 32'h0);
    chk("c0_w_req_addr", w_req_addr, 32'hFFFF_FFF8);
    chk("c0_inst_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("c1_req_addr", imem_req_addr, 32'h4);
    chk("c1_w_req_addr", w_req_addr, 32'hFFFF_FFFC);
    chk("c1_w_req_valid", {31'd0, w_req_valid}, 32'd1);
    chk("c1_inst_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("c2_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("c2_inst_pc", inst_pc, exp_q[0]);
    chk("c2_inst_data", inst_data, exp_q.pop_front());
    chk("c2_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("c3_inst_pc", inst_pc, exp_q[0]);
    chk("c3_inst_data", inst_data, exp_q.pop_front());
    chk("c3_req_addr", imem_req_addr, 32'h8);
    chk("c3_w_req_valid", {31'd0, w_req_valid}, 32'd1);
    chk("c3_w_req_addr", w_req_addr, 32'h0);
    tick();
    chk("c4_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("c4_req_addr", imem_req_addr, 32'hC);
    tick();
    chk("c5_inst_pc", inst_pc, exp_q[0]);
    chk("c5_inst_data", inst_data, exp_q.pop_front());

    // decode stalled: queue fills and requests stop
    reset      = 1'b1;
    inst_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("full_req0_addr", imem_req_addr, 32'h0);
    tick();
    chk("full_req1_addr", imem_req_addr, 32'h4);
    chk("full_req1_valid", {31'd0, imem_req_valid}, 32'd1);
    tick();
    chk("full_c2_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("full_c3_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("full_c3_inst_pc", inst_pc, 32'h0);
    tick();
    chk("full_c4_req_valid", {31'd0, imem_req_valid}, 32'd0);
    inst_ready = 1'b1;
    mem_auto   = 1'b0;
    tick();
    chk("pop_inst_pc", inst_pc, 32'h4);
    chk("pop_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("pop_req_addr", imem_req_addr, 32'h8);

    // redirect with two requests (0x8, 0xC) outstanding
    imem_resp_valid = 1'b0;
    tick();
    chk("out_req_addr", imem_req_addr, 32'hC);
    chk("out_inst_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("out2_req_valid", {31'd0, imem_req_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    #1;
    chk("redir_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("drop_credit_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("redir_fetch_addr", imem_req_addr, 32'h100);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_0008;
    tick();
    imem_resp_data = 32'hDEAD_000C;
    chk("drop1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("drop1_req_addr", imem_req_addr, 32'h100);
    chk("drop1_inst_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hAAAA_0100;
    imem_req_ready  = 1'b0;
    chk("drop2_inst_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    imem_resp_valid = 1'b0;
    chk("new_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("new_inst_pc", inst_pc, 32'h100);
    chk("new_inst_data", inst_data, 32'hAAAA_0100);

    // redirect in the same cycle as the only live response
    imem_req_ready = 1'b1;
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0055;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h200;
    #1;
    chk("coinc_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    #1;
    chk("coinc_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("coinc_req_valid_after", {31'd0, imem_req_valid}, 32'd1);
    chk("coinc_req_addr", imem_req_addr, 32'h200);

    // reset with two outstanding, then stray responses
    tick();
    chk("rs_req_addr", imem_req_addr, 32'h204);
    tick();
    chk("rs_req_valid_full", {31'd0, imem_req_valid}, 32'd0);
    reset = 1'b1;
    tick();
    tick();
    chk("rs_in_reset_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rs_in_reset_inst_valid", {31'd0, inst_valid}, 32'd0);
    reset           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0077;
    #1;
    chk("rs_first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rs_first_req_addr", imem_req_addr, 32'h0);
    tick();
    chk("stray1_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("stray1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    tick();
    imem_resp_valid = 1'b0;
    chk("stray2_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("stray2_inst_pc", inst_pc, 32'h0);
    chk("stray2_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("stray2_req_addr", imem_req_addr, 32'h0);

    // back-to-back redirects, the last one wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    #1;
    chk("b2b_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect_pc = 32'h405;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("b2b_req_valid_after", {31'd0, imem_req_valid}, 32'd1);
    chk("b2b_req_addr", imem_req_addr, 32'h404);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
